// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control FSM; optional retired-instruction counter under MULTICYCLE_INSTRET_EN
module multicycle_controller #(
    parameter int XLEN      = 32,
    parameter bit TRAP_HOLD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] types,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       illegal_instr
`ifdef MULTICYCLE_INSTRET_EN
    ,
    output logic [XLEN-1:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_L,
        CL_S,
        CL_J,
        CL_B,
        CL_U
    } class_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] WB_IMM   = 2'd3;

    state_t     r_state;
    state_t     w_next;
    class_t     r_class;
    class_t     w_dec_class;
    logic       w_dec_legal;
    logic       r_is_jal;     // opcode bit3: JAL=1, JALR=0
    logic       r_is_lui;     // opcode bit5: LUI=1, AUIPC=0
    logic       w_alu_a;
    logic       w_alu_b;
    logic [1:0] w_wb_sel;
    logic [1:0] w_wb_pc_sel;
    logic       w_unused;

    // funct3 belongs to the branch comparator; the remaining opcode bits do not affect sequencing
    assign w_unused = &{1'b0, funct3, opcode[6], opcode[4], opcode[2:0], (XLEN == 0)};

    // State register; reset parks the FSM in IDLE and abandons any open handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction class and opcode qualifiers are captured once, at the end of DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_class  <= CL_R;
            r_is_jal <= 1'b0;
            r_is_lui <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_class  <= w_dec_class;
            r_is_jal <= opcode[3];
            r_is_lui <= opcode[5];
        end
    end

    // Class decode: one-hot vectors are legal; I+J together is JALR and sequences as a jump
    always_comb begin
        w_dec_legal = 1'b1;
        w_dec_class = CL_R;
        case (types)
            7'b1000000: w_dec_class = CL_R;
            7'b0100000: w_dec_class = CL_I;
            7'b0010000: w_dec_class = CL_L;
            7'b0001000: w_dec_class = CL_S;
            7'b0000100: w_dec_class = CL_J;
            7'b0100100: w_dec_class = CL_J;
            7'b0000010: w_dec_class = CL_B;
            7'b0000001: w_dec_class = CL_U;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    // Datapath selects per class; held from EXEC through WB so the combinational ALU result stays valid
    always_comb begin
        w_alu_a     = 1'b0;
        w_alu_b     = 1'b0;
        w_wb_sel    = WB_ALU;
        w_wb_pc_sel = PC_PLUS4;
        case (r_class)
            CL_I: begin
                w_alu_b = 1'b1;
            end
            CL_L: begin
                w_alu_b  = 1'b1;
                w_wb_sel = WB_MEM;
            end
            CL_S: begin
                w_alu_b = 1'b1;
            end
            CL_J: begin
                w_alu_a     = r_is_jal;
                w_alu_b     = 1'b1;
                w_wb_sel    = WB_PC4;
                w_wb_pc_sel = r_is_jal ? PC_IMM : PC_ALU;
            end
            CL_U: begin
                w_alu_a  = ~r_is_lui;
                w_alu_b  = 1'b1;
                w_wb_sel = r_is_lui ? WB_IMM : WB_ALU;
            end
            default: begin
                w_alu_a = 1'b0;
                w_alu_b = 1'b0;
            end
        endcase
    end

    // Next state and strobes; everything is forced low while rst is asserted
    always_comb begin
        w_next        = r_state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_PLUS4;
        reg_we        = 1'b0;
        wb_sel        = WB_ALU;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        illegal_instr = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    w_next = S_FETCH;
                end
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we  = 1'b1;
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_next = w_dec_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_a_sel = w_alu_a;
                    alu_b_sel = w_alu_b;
                    case (r_class)
                        CL_L, CL_S: w_next = S_MEM;
                        CL_B: begin
                            pc_we  = 1'b1;
                            pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                            w_next = S_FETCH;
                        end
                        default: w_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    alu_a_sel = w_alu_a;
                    alu_b_sel = w_alu_b;
                    dmem_req  = 1'b1;
                    dmem_we   = (r_class == CL_S);
                    if (dmem_ack) begin
                        if (r_class == CL_S) begin
                            pc_we  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    alu_a_sel = w_alu_a;
                    alu_b_sel = w_alu_b;
                    reg_we    = 1'b1;
                    pc_we     = 1'b1;
                    wb_sel    = w_wb_sel;
                    pc_sel    = w_wb_pc_sel;
                    w_next    = S_FETCH;
                end
                S_TRAP: begin
                    illegal_instr = 1'b1;
                    if (!TRAP_HOLD) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

`ifdef MULTICYCLE_INSTRET_EN
    logic [XLEN-1:0] r_instret;

    // Every PC update outside TRAP retires exactly one instruction; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (pc_we && (r_state != S_TRAP)) begin
            r_instret <= r_instret + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] types;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       illegal_instr;
`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_pass      = 0;
    int n_fail      = 0;
    int n_total     = 0;
    int exp_instret = 0;

    logic [6:0] g_t;
    logic [6:0] g_op;
    int         g_sel;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    always #5 clk = ~clk;

    multicycle_controller #(.XLEN(32), .TRAP_HOLD(1'b0)) dut (
        .clk           (clk),
        .rst           (rst),
        .types         (types),
        .opcode        (opcode),
        .funct3        (funct3),
        .branch_taken  (branch_taken),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .alu_a_sel     (alu_a_sel),
        .alu_b_sel     (alu_b_sel),
        .illegal_instr (illegal_instr)
`ifdef MULTICYCLE_INSTRET_EN
        ,
        .instret       (instret)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_a_sel, alu_b_sel, illegal_instr};
    endfunction

    task automatic chk_instret(input string tag);
`ifdef MULTICYCLE_INSTRET_EN
        chk(tag, instret, 32'(exp_instret));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    typedef struct {
        int         cycles;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic [1:0] pc_sel;
        logic       ill;
        int         dmem_cycles;
        logic       dwe;
        logic       chk_alu;
        logic       alu_a;
        logic       alu_b;
    } exp_t;

    // Reference: per-instruction outcome derived from the class rules and the published cycle counts
    function automatic exp_t model(input logic [6:0] t, input logic [6:0] op, input logic tk,
                                   input int flat, input int dlat);
        exp_t e;
        bit   legal;
        legal         = ($countones(t) == 1) || (t == 7'b0100100);
        e.cycles      = flat + 2;
        e.reg_we      = 1'b0;
        e.wb_sel      = 2'd0;
        e.pc_sel      = 2'd0;
        e.ill         = 1'b0;
        e.dmem_cycles = 0;
        e.dwe         = 1'b0;
        e.chk_alu     = legal;
        e.alu_a       = 1'b0;
        e.alu_b       = 1'b0;
        if (!legal) begin
            e.ill    = 1'b1;
            e.cycles = e.cycles + 1;
        end else if (t[2]) begin
            e.cycles = e.cycles + 2;
            e.reg_we = 1'b1;
            e.wb_sel = 2'd2;
            e.pc_sel = op[3] ? 2'd1 : 2'd2;
            e.alu_a  = op[3];
            e.alu_b  = 1'b1;
        end else if (t[6]) begin
            e.cycles = e.cycles + 2;
            e.reg_we = 1'b1;
        end else if (t[5]) begin
            e.cycles = e.cycles + 2;
            e.reg_we = 1'b1;
            e.alu_b  = 1'b1;
        end else if (t[4]) begin
            e.cycles      = e.cycles + 3 + dlat;
            e.reg_we      = 1'b1;
            e.wb_sel      = 2'd1;
            e.dmem_cycles = dlat + 1;
            e.alu_b       = 1'b1;
        end else if (t[3]) begin
            e.cycles      = e.cycles + 2 + dlat;
            e.dmem_cycles = dlat + 1;
            e.dwe         = 1'b1;
            e.alu_b       = 1'b1;
        end else if (t[1]) begin
            e.cycles = e.cycles + 1;
            e.pc_sel = tk ? 2'd1 : 2'd0;
        end else begin
            e.cycles  = e.cycles + 2;
            e.reg_we  = 1'b1;
            e.wb_sel  = op[5] ? 2'd3 : 2'd0;
            e.chk_alu = ~op[5];
            e.alu_a   = 1'b1;
            e.alu_b   = 1'b1;
        end
        return e;
    endfunction

    // Entered #1 after the edge that starts FETCH; returns #1 after the edge that starts the next FETCH
    task automatic run_instr(input int idx, input logic [6:0] t, input logic [6:0] op, input logic tk,
                             input int flat, input int dlat);
        exp_t       e;
        int         cyc;
        int         ireq;
        int         dreq;
        int         ir_n;
        int         reg_n;
        int         ill_n;
        int         dm_n;
        int         bad;
        bit         done;
        logic       first_req;
        logic       a_obs;
        logic       b_obs;
        logic       end_reg;
        logic [1:0] end_wb;
        logic [1:0] end_psel;
        logic       end_ill;
        e            = model(t, op, tk, flat, dlat);
        types        = t;
        opcode       = op;
        branch_taken = tk;
        funct3       = 3'($urandom);
        cyc = 0; ireq = 0; dreq = 0; ir_n = 0; reg_n = 0; ill_n = 0; dm_n = 0; bad = 0;
        done = 1'b0; first_req = 1'b0; a_obs = 1'bx; b_obs = 1'bx;
        end_reg = 1'bx; end_wb = 2'bxx; end_psel = 2'bxx; end_ill = 1'bx;
        while (!done && cyc < 60) begin
            if (imem_req) begin
                imem_ack = (ireq == flat);
                ireq++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dmem_ack = (dreq == dlat);
                dreq++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (cyc == 0) first_req = imem_req;
            if (ir_we) ir_n++;
            if (reg_we) reg_n++;
            if (illegal_instr) ill_n++;
            if ((ir_we && (pc_we || reg_we)) || (reg_we && !pc_we)) bad++;
            if (dmem_req) begin
                dm_n++;
                if (dmem_we !== e.dwe) bad++;
            end
            if (cyc == flat + 2) begin
                a_obs = alu_a_sel;
                b_obs = alu_b_sel;
            end
            if (pc_we) begin
                done     = 1'b1;
                end_reg  = reg_we;
                end_wb   = wb_sel;
                end_psel = pc_sel;
                end_ill  = illegal_instr;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk($sformatf("i%0d_fetch_req", idx), 32'(first_req), 32'd1);
        chk($sformatf("i%0d_completed", idx), 32'(done), 32'd1);
        chk($sformatf("i%0d_cycles", idx), 32'(cyc), 32'(e.cycles));
        chk($sformatf("i%0d_ir_we_count", idx), 32'(ir_n), 32'd1);
        chk($sformatf("i%0d_strobe_overlap", idx), 32'(bad), 32'd0);
        chk($sformatf("i%0d_dmem_cycles", idx), 32'(dm_n), 32'(e.dmem_cycles));
        chk($sformatf("i%0d_reg_we_count", idx), 32'(reg_n), 32'(e.reg_we));
        chk($sformatf("i%0d_illegal_count", idx), 32'(ill_n), 32'(e.ill));
        chk($sformatf("i%0d_end_reg_we", idx), 32'(end_reg), 32'(e.reg_we));
        chk($sformatf("i%0d_end_pc_sel", idx), 32'(end_psel), 32'(e.pc_sel));
        chk($sformatf("i%0d_end_illegal", idx), 32'(end_ill), 32'(e.ill));
        if (e.reg_we) chk($sformatf("i%0d_wb_sel", idx), 32'(end_wb), 32'(e.wb_sel));
        if (e.chk_alu) chk($sformatf("i%0d_alu_sel", idx), 32'({a_obs, b_obs}), 32'({e.alu_a, e.alu_b}));
        if (!e.ill) exp_instret++;
        chk_instret($sformatf("i%0d_instret", idx));
    endtask

    // Starts a load, leaves it waiting on dmem_ack, then resets underneath it and offers a late ack
    task automatic reset_during_load(input int wait_cycles);
        int guard;
        types    = 7'b0010000;
        opcode   = OP_L;
        dmem_ack = 1'b0;
        guard    = 0;
        while (!dmem_req && guard < 20) begin
            imem_ack = imem_req;
            @(posedge clk);
            #1;
            guard++;
        end
        imem_ack = 1'b0;
        chk("rstld_reached_mem", 32'(dmem_req), 32'd1);
        repeat (wait_cycles) begin
            @(posedge clk);
            #1;
            chk("rstld_req_held", 32'({dmem_req, dmem_we}), 32'b10);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rstld_outs_in_rst", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstld_outs_idle", 32'(all_outs()), 32'd0);
        exp_instret = 0;
        chk_instret("rstld_instret_clr");
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("rstld_refetch", 32'({imem_req, dmem_req}), 32'b10);
    endtask

    initial begin
        rst          = 1'b1;
        types        = 7'd0;
        opcode       = 7'd0;
        funct3       = 3'd0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("rst_outs_%0d", i), 32'(all_outs()), 32'd0);
        end
        chk_instret("rst_instret");
        rst = 1'b0;
        #1;
        chk("post_rst_idle", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1;

        run_instr(0, 7'b1000000, OP_R, 1'b0, 0, 0);
        run_instr(1, 7'b0010000, OP_L, 1'b0, 0, 3);
        run_instr(2, 7'b0000010, OP_B, 1'b1, 0, 0);
        run_instr(3, 7'b0000010, OP_B, 1'b0, 0, 0);
        run_instr(4, 7'b0100100, OP_JALR, 1'b0, 1, 0);
        run_instr(5, 7'b0000000, OP_R, 1'b0, 0, 0);
        run_instr(6, 7'b0001000, OP_S, 1'b0, 2, 1);
        run_instr(7, 7'b0000001, OP_LUI, 1'b0, 0, 0);

        reset_during_load(3);

        run_instr(8, 7'b0100000, OP_I, 1'b0, 0, 0);
        run_instr(9, 7'b0000100, OP_JAL, 1'b0, 0, 0);
        run_instr(10, 7'b0000001, OP_AUIPC, 1'b0, 1, 0);
        run_instr(11, 7'b0110000, OP_R, 1'b0, 0, 0);
        run_instr(12, 7'b0001000, OP_S, 1'b0, 0, 0);
        run_instr(13, 7'b1000000, OP_R, 1'b0, 3, 0);

        for (int k = 0; k < 40; k++) begin
            g_sel = $urandom_range(0, 8);
            case (g_sel)
                0: begin g_t = 7'b1000000; g_op = OP_R; end
                1: begin g_t = 7'b0100000; g_op = OP_I; end
                2: begin g_t = 7'b0010000; g_op = OP_L; end
                3: begin g_t = 7'b0001000; g_op = OP_S; end
                4: begin g_t = 7'b0000100; g_op = OP_JAL; end
                5: begin
                    g_t  = ($urandom_range(0, 1) == 1) ? 7'b0100100 : 7'b0000100;
                    g_op = OP_JALR;
                end
                6: begin g_t = 7'b0000010; g_op = OP_B; end
                7: begin
                    g_t  = 7'b0000001;
                    g_op = ($urandom_range(0, 1) == 1) ? OP_LUI : OP_AUIPC;
                end
                default: begin
                    g_op = 7'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        g_t = 7'd0;
                    end else begin
                        do begin
                            g_t = 7'($urandom);
                        end while (($countones(g_t) < 2) || (g_t == 7'b0100100));
                    end
                end
            endcase
            run_instr(100 + k, g_t, g_op, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
